// File: rtl/bcd_scan_pkg.sv
// rtl/bcd_scan_pkg.sv - shared segment constants and BCD-to-7-segment decode for bcd_scan_ctrl
package bcd_scan_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Segment order {a,b,c,d,e,f,g}, active-high, common-cathode.
    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] i_val);
        if (i_val > 4'd9) begin
            return SEG_BLANK;
        end
        return SEG_LUT[i_val];
    endfunction

endpackage

// File: rtl/bcd_scan_ctrl_scan_timer.sv
// rtl/bcd_scan_ctrl_scan_timer.sv - slot prescaler and digit index for the display scan
module scan_timer #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 1000,
    parameter int CNT_W      = $clog2(PRESCALE),
    parameter int IDX_W      = ($clog2(NUM_DIGITS) < 1) ? 1 : $clog2(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic [IDX_W-1:0] idx,
    output logic             slot_end,
    output logic             frame_end
);

    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             w_last_idx;

    assign w_last_idx = (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign slot_end   = en && (r_cnt == CNT_W'(PRESCALE - 1));
    assign frame_end  = slot_end && w_last_idx;
    assign cnt        = r_cnt;
    assign idx        = r_idx;

    // Both counters simply hold while en is low, so scanning resumes mid-slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (slot_end) begin
            r_cnt <= '0;
            r_idx <= w_last_idx ? '0 : r_idx + 1'b1;
        end else if (en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bcd_scan_ctrl.sv
// rtl/bcd_scan_ctrl.sv - multiplexed 7-segment scan controller with frame-aligned value commit
// Optional leading-zero blanking when BCD_SCAN_LZB_EN is defined.
module bcd_scan_ctrl
    import bcd_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    load,
    output logic                    pending,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_tick
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = ($clog2(NUM_DIGITS) < 1) ? 1 : $clog2(NUM_DIGITS);

    logic [CNT_W-1:0]        w_cnt;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_slot_end;
    logic                    w_frame_end;
    logic                    w_boundary;
    logic                    w_in_blank;
    logic [3:0]              w_digit;
    logic [6:0]              w_digit_seg;
    logic [NUM_DIGITS-1:0]   w_onehot;

    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [4*NUM_DIGITS-1:0] r_pend_reg;
    logic                    r_pending;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_dig_en;
    logic                    r_frame_tick;

    scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .PRESCALE   (PRESCALE),
        .CNT_W      (CNT_W),
        .IDX_W      (IDX_W)
    ) u_scan_timer (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cnt       (w_cnt),
        .idx       (w_idx),
        .slot_end  (w_slot_end),
        .frame_end (w_frame_end)
    );

    assign w_boundary = w_slot_end && w_frame_end;
    assign w_in_blank = (w_cnt < CNT_W'(BLANK_CYCLES));
    assign w_digit    = r_disp[{w_idx, 2'b00} +: 4];
    assign w_onehot   = NUM_DIGITS'(1) << w_idx;

`ifdef BCD_SCAN_LZB_EN
    logic [NUM_DIGITS-1:0] w_lead_zero;
    logic                  w_zero_run;

    // w_lead_zero[k] is set when digit k and every digit above it are zero.
    always_comb begin
        w_lead_zero = '0;
        w_zero_run  = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_zero_run     = w_zero_run && (r_disp[4*k +: 4] == 4'd0);
            w_lead_zero[k] = w_zero_run;
        end
    end

    assign w_digit_seg = ((w_idx != '0) && w_lead_zero[w_idx]) ? SEG_BLANK : seg_decode(w_digit);
`else
    assign w_digit_seg = seg_decode(w_digit);
`endif

    // A load landing on the boundary wins the pending flag; the older value still commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp       <= '0;
            r_pend_reg   <= '0;
            r_pending    <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_boundary;
            if (w_boundary && r_pending) begin
                r_disp <= r_pend_reg;
            end
            if (load) begin
                r_pend_reg <= bcd_in;
                r_pending  <= 1'b1;
            end else if (w_boundary) begin
                r_pending  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg    <= SEG_BLANK;
            r_dig_en <= '0;
        end else if (!en || w_in_blank) begin
            r_seg    <= SEG_BLANK;
            r_dig_en <= '0;
        end else begin
            r_seg    <= w_digit_seg;
            r_dig_en <= w_onehot;
        end
    end

    assign pending    = r_pending;
    assign seg        = r_seg;
    assign dig_en     = r_dig_en;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// tb/tb_bcd_scan_ctrl.sv - directed self-checking bench for bcd_scan_ctrl (4 digits, prescale 4, blank 1)
module tb_bcd_scan_ctrl;

    localparam logic [6:0] S0 = 7'b1111110;
    localparam logic [6:0] S1 = 7'b0110000;
    localparam logic [6:0] S2 = 7'b1101101;
    localparam logic [6:0] S3 = 7'b1111001;
    localparam logic [6:0] S4 = 7'b0110011;
    localparam logic [6:0] S5 = 7'b1011011;
    localparam logic [6:0] S6 = 7'b1011111;
    localparam logic [6:0] S7 = 7'b1110000;
    localparam logic [6:0] S8 = 7'b1111111;
    localparam logic [6:0] S9 = 7'b1111011;
    localparam logic [6:0] SB = 7'b0000000;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] bcd_in;
    logic        load;
    logic        pending;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic        frame_tick;

    int tests;
    int fails;

    bcd_scan_ctrl #(
        .NUM_DIGITS   (4),
        .PRESCALE     (4),
        .BLANK_CYCLES (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .bcd_in     (bcd_in),
        .load       (load),
        .pending    (pending),
        .seg        (seg),
        .dig_en     (dig_en),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one 16-cycle frame starting just after a boundary (t=0) and ending on the next tick.
    task automatic frame(input string name,
                         input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3,
                         input int la, input logic [15:0] va,
                         input int lb, input logic [15:0] vb,
                         input logic p15, input logic p16);
        logic [6:0] segs [4];
        logic [3:0] exp_en;
        logic [6:0] exp_seg;
        segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
        for (int t = 1; t <= 16; t++) begin
            load = 1'b0;
            if (t - 1 == la) begin
                load = 1'b1; bcd_in = va;
            end else if (t - 1 == lb) begin
                load = 1'b1; bcd_in = vb;
            end
            step();
            load = 1'b0;
            if (t % 4 == 1) begin
                exp_en = 4'b0000; exp_seg = SB;
            end else begin
                exp_en = 4'b0001 << ((t - 1) / 4); exp_seg = segs[(t - 1) / 4];
            end
            chk($sformatf("%s t%0d dig_en", name, t), 32'(dig_en), 32'(exp_en));
            chk($sformatf("%s t%0d seg", name, t), 32'(seg), 32'(exp_seg));
            chk($sformatf("%s t%0d frame_tick", name, t), 32'(frame_tick), 32'(t == 16));
            if (t == 15) chk($sformatf("%s t15 pending", name), 32'(pending), 32'(p15));
            if (t == 16) chk($sformatf("%s t16 pending", name), 32'(pending), 32'(p16));
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1; en = 1'b0; load = 1'b0; bcd_in = 16'h0000;
        step(); step();
        chk("reset seg", 32'(seg), 32'(SB));
        chk("reset dig_en", 32'(dig_en), 32'd0);
        chk("reset pending", 32'(pending), 32'd0);
        chk("reset frame_tick", 32'(frame_tick), 32'd0);

        rst = 1'b0; en = 1'b1;
`ifdef BCD_SCAN_LZB_EN
        frame("f0000", S0, SB, SB, SB, 0, 16'h1234, -1, 16'h0, 1'b1, 1'b0);
`else
        frame("f0000", S0, S0, S0, S0, 0, 16'h1234, -1, 16'h0, 1'b1, 1'b0);
`endif
        frame("f1234", S4, S3, S2, S1, 3, 16'h5678, -1, 16'h0, 1'b1, 1'b0);
        frame("f5678", S8, S7, S6, S5, 2, 16'h1111, 6, 16'h2222, 1'b1, 1'b0);
        frame("f2222a", S2, S2, S2, S2, 15, 16'h3333, -1, 16'h0, 1'b0, 1'b1);
        frame("f2222b", S2, S2, S2, S2, -1, 16'h0, -1, 16'h0, 1'b1, 1'b0);
        frame("f3333", S3, S3, S3, S3, 5, 16'h00A9, -1, 16'h0, 1'b1, 1'b0);
`ifdef BCD_SCAN_LZB_EN
        frame("f00a9", S9, SB, SB, SB, 0, 16'h0050, -1, 16'h0, 1'b1, 1'b0);
        frame("f0050", S0, S5, SB, SB, 0, 16'h1234, -1, 16'h0, 1'b1, 1'b0);
`else
        frame("f00a9", S9, SB, S0, S0, 0, 16'h0050, -1, 16'h0, 1'b1, 1'b0);
        frame("f0050", S0, S5, S0, S0, 0, 16'h1234, -1, 16'h0, 1'b1, 1'b0);
`endif

        // Pause scanning mid-slot of digit 1 and confirm it resumes from the held state.
        for (int t = 1; t <= 6; t++) step();
        chk("pause pre dig_en", 32'(dig_en), 32'b0010);
        chk("pause pre seg", 32'(seg), 32'(S3));
        en = 1'b0;
        for (int t = 7; t <= 16; t++) begin
            step();
            chk($sformatf("pause t%0d dig_en", t), 32'(dig_en), 32'd0);
            chk($sformatf("pause t%0d seg", t), 32'(seg), 32'(SB));
            chk($sformatf("pause t%0d frame_tick", t), 32'(frame_tick), 32'd0);
        end
        en = 1'b1;
        step();
        chk("resume t17 dig_en", 32'(dig_en), 32'b0010);
        chk("resume t17 seg", 32'(seg), 32'(S3));
        step();
        chk("resume t18 dig_en", 32'(dig_en), 32'b0010);
        step();
        chk("resume t19 dig_en", 32'(dig_en), 32'd0);
        for (int t = 20; t <= 26; t++) begin
            step();
            if (t == 20) chk("resume t20 dig_en", 32'(dig_en), 32'b0100);
            chk($sformatf("resume t%0d frame_tick", t), 32'(frame_tick), 32'(t == 26));
        end

        // Asynchronous reset mid-frame with a value still pending.
        load = 1'b1; bcd_in = 16'h9999;
        step();
        load = 1'b0;
        chk("rst pre pending", 32'(pending), 32'd1);
        step(); step();
        chk("rst pre dig_en", 32'(dig_en), 32'b0001);
        chk("rst pre seg", 32'(seg), 32'(S4));
        #2;
        rst = 1'b1;
        #1;
        chk("rst async seg", 32'(seg), 32'(SB));
        chk("rst async dig_en", 32'(dig_en), 32'd0);
        chk("rst async pending", 32'(pending), 32'd0);
        chk("rst async frame_tick", 32'(frame_tick), 32'd0);
        @(negedge clk);
        step();
        rst = 1'b0;
`ifdef BCD_SCAN_LZB_EN
        frame("fpost", S0, SB, SB, SB, -1, 16'h0, -1, 16'h0, 1'b0, 1'b0);
`else
        frame("fpost", S0, S0, S0, S0, -1, 16'h0, -1, 16'h0, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
